// File: rtl/cpu_step_ctrl_pkg.sv
// Shared encodings for the CPU debug step controller: FSM states and button roles.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam int BTN_RUN   = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_SPEED = 2;
  localparam int BTN_PAGE  = 3;

  // How far each faster speed shortens the run period, in powers of two.
  localparam int SPEED1_SHIFT = 4;
  localparam int SPEED2_SHIFT = 8;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// One push-button: 2-FF synchronizer, stable-count debounce, press pulse on 0->1.
module cpu_step_ctrl_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_50mhz,
  input  logic reset_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic pressed_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pressed_q, pressed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_sync;

  // Released pins idle high, so the synchronizer resets to "released".
  assign btn_sync = ~sync2_q;

  // Two-stage synchronizer for the asynchronous pin.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    pressed_d = 1'b0;
    if (btn_sync != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d   = ~level_q;
        pressed_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state; the press pulse lands on the same cycle the level first reads 1.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pressed_q <= pressed_d;
    end
  end

  assign level_o   = level_q;
  assign pressed_o = pressed_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Front-panel debug path: debounced buttons drive a HALT/RUN/STEP controller
// that produces the CPU clock-enable at a selectable run rate.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV_LOG2    = 24
) (
  input  logic               clk_50mhz,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic               cpu_ce,
  output logic               run_mode,
  output logic [1:0]         speed_sel,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pressed
);

  state_e                  state_q, state_d;
  logic [1:0]              speed_q, speed_d;
  logic [RUN_DIV_LOG2-1:0] div_q, div_d, tick_mask;
  logic                    tick;
  logic                    press_run, press_step, press_speed;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    cpu_step_ctrl_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_50mhz(clk_50mhz),
      .reset_n  (reset_n),
      .btn_n_i  (btn_n[g]),
      .level_o  (btn_level[g]),
      .pressed_o(btn_pressed[g])
    );
  end

  assign press_run   = btn_pressed[BTN_RUN];
  assign press_step  = btn_pressed[BTN_STEP];
  assign press_speed = btn_pressed[BTN_SPEED];

  // Select how many low divider bits must be ones for a tick at the current speed.
  always_comb begin
    tick_mask = '0;
    case (speed_q)
      2'd0:    tick_mask = '1;
      2'd1:    tick_mask = {RUN_DIV_LOG2{1'b1}} >> SPEED1_SHIFT;
      2'd2:    tick_mask = {RUN_DIV_LOG2{1'b1}} >> SPEED2_SHIFT;
      default: tick_mask = '0;
    endcase
  end

  // A speed change restarts the divider, so that cycle must not tick.
  assign tick = ((div_q & tick_mask) == tick_mask) && !press_speed;

  // Next state, speed and divider, plus the clock-enable for the current state.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    div_d   = div_q + 1'b1;
    cpu_ce  = 1'b0;
    if (press_speed) begin
      speed_d = speed_q + 2'd1;
      div_d   = '0;
    end
    unique case (state_q)
      ST_HALT: begin
        if (press_run) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (press_step) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        cpu_ce  = 1'b1;
        state_d = ST_HALT;
      end
      ST_RUN: begin
        if (press_run) begin
          state_d = ST_HALT;
        end else begin
          cpu_ce = tick;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Controller registers; reset lands in HALT so no enable pulse follows release.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HALT;
      speed_q <= 2'd0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      div_q   <= div_d;
    end
  end

  assign run_mode  = (state_q == ST_RUN);
  assign speed_sel = speed_q;

endmodule
